// File: rtl/vctr_sqr_accum.sv
// vctr_sqr_accum: drains one N-word vector from the upstream FIFO stage,
// squares each word and accumulates the squared L2 norm, then presents the
// scalar over a valid/ack handshake.
// Optional build macro: VCTR_ACCUM_SATURATE_EN (saturating accumulator;
// without it the accumulator wraps modulo 2^ACC_WIDTH).
module vctr_sqr_accum #(
    parameter int WORD_WIDTH      = 16,
    parameter int HSP_BANDS_WIDTH = 3,
    parameter int ACC_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  vctr_ready,
    output logic                  vctr_rd_en,
    input  logic [WORD_WIDTH-1:0] vctr_data,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic                  idle,
    output logic                  busy
);
    localparam int N    = 1 << HSP_BANDS_WIDTH;
    localparam int SQ_W = 2 * WORD_WIDTH;

    generate
        if (ACC_WIDTH < SQ_W) begin : g_acc_too_narrow
            $error("vctr_sqr_accum: ACC_WIDTH must be >= 2*WORD_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t                     state;
    logic [HSP_BANDS_WIDTH-1:0] cnt;
    logic                       v1;
    logic                       v2;
    logic [SQ_W-1:0]            sq;
    logic [ACC_WIDTH-1:0]       acc;
    logic [ACC_WIDTH-1:0]       acc_nxt;
    logic [ACC_WIDTH:0]         sum;

    // Reads follow upstream readiness directly so a stall costs no cycles.
    assign vctr_rd_en = (state == S_FETCH) && vctr_ready;

    // Next accumulator value: carry-out kept in sum's top bit.
    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - SQ_W){1'b0}}, sq};
        acc_nxt = acc;
        if (v2) begin
            acc_nxt = sum[ACC_WIDTH-1:0];
`ifdef VCTR_ACCUM_SATURATE_EN
            // Once clamped, every later add carries out again (or adds 0),
            // so the value stays pinned at all-ones for the rest of the vector.
            if (sum[ACC_WIDTH]) acc_nxt = '1;
`endif
        end
    end

    // Square/accumulate pipeline; cleared when a new vector begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            sq  <= '0;
            acc <= '0;
        end else if (state == S_WAIT && vctr_ready) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            acc <= '0;
        end else begin
            v1  <= vctr_rd_en;
            v2  <= v1;
            if (v1) sq <= SQ_W'(vctr_data) * SQ_W'(vctr_data);
            acc <= acc_nxt;
        end
    end

    // Control FSM with registered status outputs and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            idle         <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WAIT;
                        idle  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (vctr_ready) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    if (vctr_rd_en) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == HSP_BANDS_WIDTH'(N - 1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // v1 low means the final square sits in stage 3 this cycle;
                    // after this edge both valid bits are clear, so capture the
                    // accumulator including that last add.
                    if (!v1) begin
                        state        <= S_RESULT;
                        result       <= acc_nxt;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                S_RESULT: begin
                    if (result_ack) begin
                        state        <= S_IDLE;
                        result_valid <= 1'b0;
                        idle         <= 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    result_valid <= 1'b0;
                    idle         <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vctr_sqr_accum.sv
// Testbench for vctr_sqr_accum: table-driven directed runs, reset abort,
// back-to-back runs and randomized runs against a behavioural model.
module tb_vctr_sqr_accum;
    localparam int N = 8;
`ifdef VCTR_ACCUM_SATURATE_EN
    localparam logic [31:0] EXP_FFFF = 32'hFFFF_FFFF;
    localparam bit          SAT      = 1'b1;
`else
    localparam logic [31:0] EXP_FFFF = 32'hFFF0_0008;
    localparam bit          SAT      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        vctr_ready = 1'b0;
    logic        vctr_rd_en;
    logic [15:0] vctr_data = '0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        idle;
    logic        busy;

    vctr_sqr_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vctr_ready(vctr_ready),
        .vctr_rd_en(vctr_rd_en), .vctr_data(vctr_data), .result(result),
        .result_valid(result_valid), .result_ack(result_ack),
        .idle(idle), .busy(busy)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nbad = 0;
    logic [15:0] words[N];
    bit          rdy[160];
    bit          exp_rd[160];
    int          model_vc;

    typedef struct {
        int          kind;     // 0: 1..8, 1: all FFFF, 2: all 3, 3: all 0
        bit          stall;    // ready low 3 cycles after the 4th read
        int          ack_dly;
        bit          noise;    // start pulses while result pending
        bit          chain;    // next run starts in the IDLE re-entry cycle
        logic [31:0] exp_res;
        int          exp_vc;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        ncmp++;
        if (!ok) begin
            nbad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk(idle === 1'b1 && busy === 1'b0 && vctr_rd_en === 1'b0 &&
            result_valid === 1'b0 && result === 32'd0, nm,
            {idle, busy, vctr_rd_en, result_valid, (result != 0)}, 5'b10000);
    endtask

    // Squared L2 norm from plain wide arithmetic.
    function automatic logic [31:0] model_sum();
        logic [63:0] s = 0;
        for (int i = 0; i < N; i++) begin
            s += 64'(words[i]) * 64'(words[i]);
            if (SAT && s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
        end
        return s[31:0];
    endfunction

    // Read schedule: WAIT from cycle 1 until ready, then one read per ready
    // cycle until N reads; result appears 3 cycles after the last read.
    function automatic void model_sched();
        int c = 1, n = 0, last = 0;
        foreach (exp_rd[i]) exp_rd[i] = 1'b0;
        while (c < 150 && !rdy[c]) c++;
        c++;
        while (c < 150 && n < N) begin
            if (rdy[c]) begin
                exp_rd[c] = 1'b1;
                n++;
                last = c;
            end
            c++;
        end
        model_vc = last + 3;
    endfunction

    function automatic void fill(input int kind);
        for (int i = 0; i < N; i++)
            case (kind)
                0: words[i] = 16'(i + 1);
                1: words[i] = 16'hFFFF;
                2: words[i] = 16'd3;
                3: words[i] = 16'd0;
                default: words[i] = 16'd2;
            endcase
    endfunction

    task automatic run(input logic [31:0] exp_res, input int exp_vc, input int ack_dly,
                       input bit noise, input bit skip, input bit chain, input string nm);
        int          nrd = 0, vc = -1, vcnt = 0, ack_c = -1, rd_err = 0, ptr = 0;
        bit          done = 0, stable_err = 0, rd_prev = 0;
        logic [31:0] res0 = '0;
        model_sched();
        for (int c = (skip ? 1 : 0); c < 150 && !done; c++) begin
            @(posedge clk);
            #1;
            if (rd_prev && ptr < N) begin
                vctr_data = words[ptr];
                ptr++;
            end
            vctr_ready = rdy[c];
            start      = (c == 0);
            result_ack = 1'b0;
            if (result_valid) begin
                if (noise) start = c[0];
                if (vcnt == ack_dly) begin
                    result_ack = 1'b1;
                    ack_c      = c;
                    start      = 1'b0;
                end
                vcnt++;
            end
            if (ack_c >= 0 && c == ack_c + 1) start = chain;
            @(negedge clk);
            rd_prev = vctr_rd_en;
            if (vctr_rd_en !== exp_rd[c]) rd_err++;
            if (vctr_rd_en) nrd++;
            if (result_valid === 1'b1) begin
                if (vc < 0) begin
                    vc   = c;
                    res0 = result;
                end else if (result !== res0) stable_err = 1;
            end
            if (ack_c >= 0 && c == ack_c + 1) begin
                chk(idle === 1'b1 && busy === 1'b0 && result_valid === 1'b0,
                    {nm, ".idle_after_ack"}, {idle, busy, result_valid}, 3'b100);
                done = 1;
            end
        end
        chk(done, {nm, ".timeout"}, done, 1);
        chk(rd_err == 0, {nm, ".rd_en_pattern"}, rd_err, 0);
        chk(nrd == N, {nm, ".reads"}, nrd, N);
        chk(res0 === exp_res, {nm, ".result"}, res0, exp_res);
        chk(vc == exp_vc, {nm, ".valid_cycle"}, vc, exp_vc);
        chk(!stable_err && vcnt == ack_dly + 1, {nm, ".valid_hold"}, vcnt, ack_dly + 1);
        if (!chain) start = 1'b0;
        result_ack = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 0, 0,  0, 0, 32'd204, 12};
        tbl[1] = '{0, 1, 0,  0, 0, 32'd204, 15};
        tbl[2] = '{1, 0, 1,  0, 0, EXP_FFFF, 12};
        tbl[3] = '{0, 0, 10, 1, 0, 32'd204, 12};
        tbl[4] = '{2, 0, 0,  0, 1, 32'd72,  12};
        tbl[5] = '{3, 0, 0,  0, 0, 32'd0,   12};

        repeat (2) @(posedge clk);
        #1 chk_reset("reset_state");
        @(negedge clk) rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            fill(tbl[t].kind);
            foreach (rdy[i]) rdy[i] = 1'b1;
            if (tbl[t].stall) begin
                rdy[6] = 1'b0;
                rdy[7] = 1'b0;
                rdy[8] = 1'b0;
            end
            run(tbl[t].exp_res, tbl[t].exp_vc, tbl[t].ack_dly, tbl[t].noise,
                (t > 0) && tbl[t-1].chain, tbl[t].chain, $sformatf("tbl%0d", t));
        end

        // Abort a run with reset during the 5th read.
        begin
            int  n = 0;
            bit  hit = 0;
            fill(0);
            for (int c = 0; c < 30 && !hit; c++) begin
                @(posedge clk);
                #1;
                start      = (c == 0);
                vctr_ready = 1'b1;
                @(negedge clk);
                if (vctr_rd_en) n++;
                if (n == 5) hit = 1;
            end
            chk(hit, "abort.reach_5th_read", n, 5);
            rst_n = 1'b0;
            #1 chk_reset("abort.async_reset");
            start      = 1'b0;
            vctr_ready = 1'b0;
            @(posedge clk);
            #1 chk_reset("abort.reset_held");
            @(negedge clk) rst_n = 1'b1;
            fill(4);
            foreach (rdy[i]) rdy[i] = 1'b1;
            run(32'd32, 12, 0, 0, 0, 0, "after_abort");
        end

        // Randomized runs: random words, ready gaps and ack delay.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                words[i] = (r % 3 == 0) ? 16'hFFFF - 16'($urandom_range(0, 255))
                                        : 16'($urandom);
            foreach (rdy[i]) rdy[i] = ($urandom_range(0, 9) < 7);
            model_sched();
            run(model_sum(), model_vc, $urandom_range(0, 3), r[0], 0, 0,
                $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
